// File: rtl/multi_alarm_trigger_pkg.sv
// Shared types and default constants for the multi-channel alarm trigger.
// The snooze feature is built only when MULTI_ALARM_SNOOZE_EN is defined.
package multi_alarm_trigger_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RINGING  = 2'd1,
      ST_SNOOZING = 2'd2
   } chan_state_e;

   localparam int unsigned DEF_NUM_ALARMS       = 4;
   localparam int unsigned DEF_IDX_W            = 2;
   localparam int unsigned DEF_TIME_W           = 6;
   localparam int unsigned DEF_SNOOZE_MIN       = 5;
   localparam int unsigned DEF_RING_TIMEOUT_MIN = 10;
   localparam int unsigned DEF_MAX_SNOOZES      = 3;

   // Minute counters cover the 1..63 range of both timeouts.
   localparam int unsigned CNT_W  = 6;
   localparam int unsigned USED_W = 8;

endpackage

// File: rtl/multi_alarm_trigger_if.sv
// Clock-time, alarm-table write, user-button and status bundle of the alarm trigger.
interface multi_alarm_trigger_if
   import multi_alarm_trigger_pkg::*;
#(
   parameter int unsigned NUM_ALARMS = DEF_NUM_ALARMS,
   parameter int unsigned IDX_W      = DEF_IDX_W,
   parameter int unsigned TIME_W     = DEF_TIME_W
);
   logic                  pulse1min;
   logic [TIME_W-1:0]     clockMinutes;
   logic [TIME_W-1:0]     clockHours;
   logic                  wr_en;
   logic [IDX_W-1:0]      wr_idx;
   logic [TIME_W-1:0]     wr_minutes;
   logic [TIME_W-1:0]     wr_hours;
   logic                  wr_enable;
   logic                  snooze;
   logic                  dismiss;
   logic                  alarmOn;
   logic [NUM_ALARMS-1:0] ringMask;
   logic [NUM_ALARMS-1:0] snoozeMask;
   logic [NUM_ALARMS-1:0] missedMask;

   modport master (
      output pulse1min, clockMinutes, clockHours,
      output wr_en, wr_idx, wr_minutes, wr_hours, wr_enable,
      output snooze, dismiss,
      input  alarmOn, ringMask, snoozeMask, missedMask
   );

   modport slave (
      input  pulse1min, clockMinutes, clockHours,
      input  wr_en, wr_idx, wr_minutes, wr_hours, wr_enable,
      input  snooze, dismiss,
      output alarmOn, ringMask, snoozeMask, missedMask
   );
endinterface

// File: rtl/multi_alarm_trigger_channel.sv
// One alarm channel: programmed time, edge-detected match and ring/snooze/timeout FSM.
// Snooze timer and snooze count exist only when MULTI_ALARM_SNOOZE_EN is defined.
module multi_alarm_trigger_channel
   import multi_alarm_trigger_pkg::*;
#(
   parameter int unsigned TIME_W           = DEF_TIME_W,
   parameter int unsigned SNOOZE_MIN       = DEF_SNOOZE_MIN,
   parameter int unsigned RING_TIMEOUT_MIN = DEF_RING_TIMEOUT_MIN,
   parameter int unsigned MAX_SNOOZES      = DEF_MAX_SNOOZES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_pulse,
   input  logic [TIME_W-1:0] i_clk_min,
   input  logic [TIME_W-1:0] i_clk_hr,
   input  logic              i_wr,
   input  logic [TIME_W-1:0] i_wr_min,
   input  logic [TIME_W-1:0] i_wr_hr,
   input  logic              i_wr_arm,
   input  logic              i_snooze,
   input  logic              i_dismiss,
   output logic              o_ringing_c,
   output logic              o_ring,
   output logic              o_snz,
   output logic              o_missed
);
   chan_state_e       r_state;
   logic [TIME_W-1:0] r_alarm_min;
   logic [TIME_W-1:0] r_alarm_hr;
   logic              r_armed;
   logic              r_match_q;
   logic [CNT_W-1:0]  r_ring_cnt;
   logic              r_missed;
   logic              r_ring;
   logic              r_missed_o;

   logic w_match;
   logic w_trigger;
   logic w_wr_match;
   logic w_end_ring;
   logic w_snz_go;
   logic w_snz_done;

   assign w_match    = r_armed && (r_alarm_hr == i_clk_hr) && (r_alarm_min == i_clk_min);
   assign w_trigger  = w_match && !r_match_q;
   assign w_wr_match = i_wr_arm && (i_wr_hr == i_clk_hr) && (i_wr_min == i_clk_min);

`ifdef MULTI_ALARM_SNOOZE_EN
   logic [CNT_W-1:0]  r_snz_tmr;
   logic [USED_W-1:0] r_snz_used;
   logic              r_snz;

   // A snooze beyond the allowance behaves like dismiss.
   assign w_end_ring = i_dismiss || (i_snooze && (r_snz_used == USED_W'(MAX_SNOOZES)));
   assign w_snz_go   = (r_state == ST_RINGING) && i_snooze && !w_end_ring;
   assign w_snz_done = (r_state == ST_SNOOZING) && i_pulse && (r_snz_tmr == CNT_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_snz_tmr  <= '0;
         r_snz_used <= '0;
         r_snz      <= 1'b0;
      end else begin
         r_snz <= (r_state == ST_SNOOZING);
         if (i_wr) begin
            r_snz_tmr  <= '0;
            r_snz_used <= '0;
         end else if ((r_state == ST_IDLE) && w_trigger) begin
            r_snz_used <= '0;
         end else if (w_snz_go) begin
            r_snz_tmr  <= CNT_W'(SNOOZE_MIN);
            r_snz_used <= r_snz_used + USED_W'(1);
         end else if ((r_state == ST_SNOOZING) && !i_dismiss && i_pulse && (r_snz_tmr != '0)) begin
            r_snz_tmr <= r_snz_tmr - CNT_W'(1);
         end
      end
   end

   assign o_snz = r_snz;
`else
   logic w_unused_cfg;

   assign w_end_ring   = i_dismiss;
   assign w_snz_go     = 1'b0;
   assign w_snz_done   = 1'b0;
   assign w_unused_cfg = ^{i_snooze, CNT_W'(SNOOZE_MIN), USED_W'(MAX_SNOOZES)};
   assign o_snz        = 1'b0;
`endif

   // Channel FSM; a table write overrides everything else in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_alarm_min <= '0;
         r_alarm_hr  <= '0;
         r_armed     <= 1'b0;
         r_match_q   <= 1'b0;
         r_ring_cnt  <= '0;
         r_missed    <= 1'b0;
         r_ring      <= 1'b0;
         r_missed_o  <= 1'b0;
      end else begin
         r_ring     <= (r_state == ST_RINGING);
         r_missed_o <= r_missed;
         if (i_wr) begin
            r_alarm_min <= i_wr_min;
            r_alarm_hr  <= i_wr_hr;
            r_armed     <= i_wr_arm;
            r_state     <= ST_IDLE;
            r_ring_cnt  <= '0;
            r_missed    <= 1'b0;
            r_match_q   <= w_wr_match;
         end else begin
            r_match_q <= w_match;
            if (i_dismiss || w_trigger) begin
               r_missed <= 1'b0;
            end
            unique case (r_state)
               ST_IDLE: begin
                  if (w_trigger) begin
                     r_state    <= ST_RINGING;
                     r_ring_cnt <= '0;
                  end
               end
               ST_RINGING: begin
                  if (w_end_ring) begin
                     r_state <= ST_IDLE;
                  end else if (w_snz_go) begin
                     r_state <= ST_SNOOZING;
                  end else if (w_trigger) begin
                     r_ring_cnt <= '0;
                  end else if (i_pulse) begin
                     if (r_ring_cnt == CNT_W'(RING_TIMEOUT_MIN - 1)) begin
                        r_state  <= ST_IDLE;
                        r_missed <= 1'b1;
                     end else begin
                        r_ring_cnt <= r_ring_cnt + CNT_W'(1);
                     end
                  end
               end
               ST_SNOOZING: begin
                  if (i_dismiss) begin
                     r_state <= ST_IDLE;
                  end else if (w_snz_done) begin
                     r_state    <= ST_RINGING;
                     r_ring_cnt <= '0;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign o_ringing_c = (r_state == ST_RINGING);
   assign o_ring      = r_ring;
   assign o_missed    = r_missed_o;

endmodule

// File: rtl/multi_alarm_trigger.sv
// Multi-channel alarm trigger: alarm-table write decode, channel array and combined alarmOn.
// Snooze support is compiled in only when MULTI_ALARM_SNOOZE_EN is defined.
module multi_alarm_trigger
   import multi_alarm_trigger_pkg::*;
#(
   parameter int unsigned NUM_ALARMS       = DEF_NUM_ALARMS,
   parameter int unsigned IDX_W            = DEF_IDX_W,
   parameter int unsigned TIME_W           = DEF_TIME_W,
   parameter int unsigned SNOOZE_MIN       = DEF_SNOOZE_MIN,
   parameter int unsigned RING_TIMEOUT_MIN = DEF_RING_TIMEOUT_MIN,
   parameter int unsigned MAX_SNOOZES      = DEF_MAX_SNOOZES
) (
   input logic                    clk5MHz,
   input logic                    reset,
   multi_alarm_trigger_if.slave   bus
);
   logic [NUM_ALARMS-1:0] w_wr_hit;
   logic [NUM_ALARMS-1:0] w_ringing;
   logic [NUM_ALARMS-1:0] w_ring;
   logic [NUM_ALARMS-1:0] w_snz;
   logic [NUM_ALARMS-1:0] w_missed;
   logic                  r_alarm_on;

   // Out-of-range indices match no channel and are dropped.
   for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_ch
      assign w_wr_hit[g] = bus.wr_en && (bus.wr_idx == IDX_W'(g));

      multi_alarm_trigger_channel #(
         .TIME_W           (TIME_W),
         .SNOOZE_MIN       (SNOOZE_MIN),
         .RING_TIMEOUT_MIN (RING_TIMEOUT_MIN),
         .MAX_SNOOZES      (MAX_SNOOZES)
      ) u_ch (
         .clk         (clk5MHz),
         .rst         (reset),
         .i_pulse     (bus.pulse1min),
         .i_clk_min   (bus.clockMinutes),
         .i_clk_hr    (bus.clockHours),
         .i_wr        (w_wr_hit[g]),
         .i_wr_min    (bus.wr_minutes),
         .i_wr_hr     (bus.wr_hours),
         .i_wr_arm    (bus.wr_enable),
         .i_snooze    (bus.snooze),
         .i_dismiss   (bus.dismiss),
         .o_ringing_c (w_ringing[g]),
         .o_ring      (w_ring[g]),
         .o_snz       (w_snz[g]),
         .o_missed    (w_missed[g])
      );
   end

   // Registered from channel state so it lines up with ringMask.
   always_ff @(posedge clk5MHz or posedge reset) begin
      if (reset) begin
         r_alarm_on <= 1'b0;
      end else begin
         r_alarm_on <= |w_ringing;
      end
   end

   assign bus.alarmOn    = r_alarm_on;
   assign bus.ringMask   = w_ring;
   assign bus.snoozeMask = w_snz;
   assign bus.missedMask = w_missed;

endmodule

// File: tb/tb_multi_alarm_trigger.sv
// Bench for multi_alarm_trigger: directed scenarios plus random traffic against a minute-level model.
// Follows MULTI_ALARM_SNOOZE_EN like the design.
module tb_multi_alarm_trigger;
   localparam int N    = 4;
   localparam int IW   = 3;
   localparam int TW   = 6;
   localparam int SNZ  = 5;
   localparam int TMO  = 10;
   localparam int MAXS = 3;
`ifdef MULTI_ALARM_SNOOZE_EN
   localparam bit SNZ_EN = 1'b1;
`else
   localparam bit SNZ_EN = 1'b0;
`endif

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   multi_alarm_trigger_if #(.NUM_ALARMS(N), .IDX_W(IW), .TIME_W(TW)) bus ();

   multi_alarm_trigger #(
      .NUM_ALARMS(N), .IDX_W(IW), .TIME_W(TW),
      .SNOOZE_MIN(SNZ), .RING_TIMEOUT_MIN(TMO), .MAX_SNOOZES(MAXS)
   ) dut (
      .clk5MHz (clk),
      .reset   (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #100 clk = ~clk;

   // Model: channel mode 0 silent, 1 ringing, 2 snoozing; times kept as plain ints.
   int m_mode[N];
   int m_hr[N];
   int m_min[N];
   bit m_arm[N];
   bit m_prev[N];
   bit m_missed[N];
   int m_rang_min[N];
   int m_snz_left[N];
   int m_snz_used[N];
   logic [N-1:0] exp_ring;
   logic [N-1:0] exp_snz;
   logic [N-1:0] exp_missed;
   logic         exp_on;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_mode[i] = 0; m_hr[i] = 0; m_min[i] = 0; m_arm[i] = 0; m_prev[i] = 0;
         m_missed[i] = 0; m_rang_min[i] = 0; m_snz_left[i] = 0; m_snz_used[i] = 0;
      end
      exp_ring = '0; exp_snz = '0; exp_missed = '0; exp_on = 1'b0;
   endtask

   task automatic model_edge();
      bit now_match;
      bit fire;
      bit snz_req;
      // Status outputs show the channel situation from before this edge.
      for (int i = 0; i < N; i++) begin
         exp_ring[i]   = (m_mode[i] == 1);
         exp_snz[i]    = (m_mode[i] == 2);
         exp_missed[i] = m_missed[i];
      end
      exp_on = |exp_ring;
      for (int i = 0; i < N; i++) begin
         now_match = m_arm[i] && (m_hr[i] == int'(bus.clockHours)) && (m_min[i] == int'(bus.clockMinutes));
         if (bus.wr_en && int'(bus.wr_idx) == i) begin
            m_hr[i] = int'(bus.wr_hours); m_min[i] = int'(bus.wr_minutes); m_arm[i] = bus.wr_enable;
            m_mode[i] = 0; m_rang_min[i] = 0; m_snz_left[i] = 0; m_snz_used[i] = 0; m_missed[i] = 0;
            m_prev[i] = bus.wr_enable && (bus.wr_hours == bus.clockHours) && (bus.wr_minutes == bus.clockMinutes);
            continue;
         end
         fire = now_match && !m_prev[i];
         m_prev[i] = now_match;
         if (bus.dismiss || fire) m_missed[i] = 0;
         snz_req = SNZ_EN && bus.snooze;
         if (m_mode[i] == 0) begin
            if (fire) begin m_mode[i] = 1; m_rang_min[i] = 0; m_snz_used[i] = 0; end
         end else if (m_mode[i] == 1) begin
            if (bus.dismiss || (snz_req && m_snz_used[i] >= MAXS)) m_mode[i] = 0;
            else if (snz_req) begin m_mode[i] = 2; m_snz_left[i] = SNZ; m_snz_used[i]++; end
            else if (fire) m_rang_min[i] = 0;
            else if (bus.pulse1min) begin
               m_rang_min[i]++;
               if (m_rang_min[i] >= TMO) begin m_mode[i] = 0; m_missed[i] = 1; end
            end
         end else begin
            if (bus.dismiss) m_mode[i] = 0;
            else if (bus.pulse1min) begin
               m_snz_left[i]--;
               if (m_snz_left[i] == 0) begin m_mode[i] = 1; m_rang_min[i] = 0; end
            end
         end
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".ringMask"},   32'(bus.ringMask),   32'(exp_ring));
      check({tag, ".snoozeMask"}, 32'(bus.snoozeMask), 32'(exp_snz));
      check({tag, ".missedMask"}, 32'(bus.missedMask), 32'(exp_missed));
      check({tag, ".alarmOn"},    32'(bus.alarmOn),    32'(exp_on));
   endtask

   // One clock: inputs were set at the previous negedge, sampled at posedge, checked at negedge.
   task automatic step(input string tag = "cyc");
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all(tag);
      bus.wr_en = 1'b0; bus.snooze = 1'b0; bus.dismiss = 1'b0; bus.pulse1min = 1'b0;
   endtask

   task automatic set_clock(input int h, input int m);
      bus.clockHours = TW'(h); bus.clockMinutes = TW'(m);
      step("clk");
   endtask

   task automatic write_ch(input int idx, input int h, input int m, input bit en);
      bus.wr_en = 1'b1; bus.wr_idx = IW'(idx); bus.wr_hours = TW'(h);
      bus.wr_minutes = TW'(m); bus.wr_enable = en;
      step("wr");
   endtask

   task automatic pulses(input int n);
      for (int k = 0; k < n; k++) begin
         bus.pulse1min = 1'b1;
         step("pulse");
      end
   endtask

   task automatic press(input bit s, input bit d);
      bus.snooze = s; bus.dismiss = d;
      step("btn");
   endtask

   // Asynchronous reset applied away from the clock edge; outputs must drop at once.
   task automatic do_reset(input string tag);
      rst = 1'b1;
      #1;
      model_reset();
      compare_all(tag);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      n_checks = 0; n_errors = 0;
      rst = 1'b1;
      bus.pulse1min = 1'b0; bus.clockMinutes = '0; bus.clockHours = '0;
      bus.wr_en = 1'b0; bus.wr_idx = '0; bus.wr_minutes = '0; bus.wr_hours = '0;
      bus.wr_enable = 1'b0; bus.snooze = 1'b0; bus.dismiss = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      compare_all("reset");
      rst = 1'b0;

      // Channel 1 at 07:30 fires one cycle after the matching minute is sampled.
      bus.clockHours = TW'(7); bus.clockMinutes = TW'(29);
      write_ch(1, 7, 30, 1'b1);
      set_clock(7, 30);
      check("t1_ring_lag", 32'(bus.ringMask), 32'h0);
      step("t1");
      check("t1_ring", 32'(bus.ringMask), 32'h2);
      check("t1_on", 32'(bus.alarmOn), 32'h1);

      // Unanswered for the timeout period: missed, then dismiss clears it.
      pulses(TMO);
      step("t2");
      check("t2_missed", 32'(bus.missedMask), 32'h2);
      check("t2_on", 32'(bus.alarmOn), 32'h0);
      press(1'b0, 1'b1);
      step("t2b");
      check("t2_missed_clr", 32'(bus.missedMask), 32'h0);

      // Snooze cycles up to the allowance; one more snooze ends the alarm.
      set_clock(7, 31);
      set_clock(7, 30);
      step("t3");
      for (int k = 0; k < MAXS; k++) begin
         press(1'b1, 1'b0);
         step("t3s");
         if (SNZ_EN) begin
            check("t3_snz", 32'(bus.snoozeMask), 32'h2);
            check("t3_snz_on", 32'(bus.alarmOn), 32'h0);
         end
         pulses(SNZ);
         step("t3r");
      end
      if (SNZ_EN) check("t3_ring_again", 32'(bus.ringMask), 32'h2);
      press(1'b1, 1'b0);
      step("t3x");
      if (SNZ_EN) check("t3_over_max", 32'(bus.ringMask), 32'h0);
      press(1'b0, 1'b1);

      // Two channels on the same time; one dismiss clears both; dismiss beats snooze.
      bus.clockHours = TW'(5); bus.clockMinutes = TW'(59);
      write_ch(0, 6, 0, 1'b1);
      write_ch(2, 6, 0, 1'b1);
      set_clock(6, 0);
      step("t4");
      check("t4_ring", 32'(bus.ringMask), 32'h5);
      press(1'b0, 1'b1);
      step("t4d");
      check("t4_dismiss", 32'(bus.ringMask), 32'h0);
      set_clock(6, 1);
      set_clock(6, 0);
      step("t4r");
      check("t4_ring2", 32'(bus.ringMask), 32'h5);
      press(1'b1, 1'b1);
      step("t4sd");
      check("t4_sd_ring", 32'(bus.ringMask), 32'h0);
      check("t4_sd_snz", 32'(bus.snoozeMask), 32'h0);

      // Writing the current time does not fire; an out-of-range index changes nothing.
      set_clock(12, 15);
      write_ch(3, 12, 15, 1'b1);
      repeat (3) step("t5");
      check("t5_no_fire", 32'(bus.ringMask), 32'h0);
      write_ch(5, 12, 16, 1'b1);
      set_clock(12, 16);
      repeat (2) step("t5b");
      check("t5_bad_idx", 32'(bus.ringMask), 32'h0);

      // Reset while snoozing drops everything and loses the table.
      set_clock(7, 29);
      set_clock(7, 30);
      step("t6");
      press(1'b1, 1'b0);
      step("t6s");
      do_reset("t6_rst");
      set_clock(7, 29);
      set_clock(7, 30);
      repeat (2) step("t6b");
      check("t6_table_lost", 32'(bus.ringMask), 32'h0);

      // Random traffic on a tiny time range so matches and retriggers are frequent.
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 399) == 0) begin
            do_reset("rnd_rst");
            continue;
         end
         if ($urandom_range(0, 5) == 0) begin
            bus.clockHours = TW'($urandom_range(0, 1));
            bus.clockMinutes = TW'($urandom_range(0, 3));
         end
         if ($urandom_range(0, 7) == 0) begin
            bus.wr_en = 1'b1;
            bus.wr_idx = IW'($urandom_range(0, 5));
            bus.wr_hours = TW'($urandom_range(0, 1));
            bus.wr_minutes = TW'($urandom_range(0, 3));
            bus.wr_enable = ($urandom_range(0, 3) != 0);
         end
         bus.pulse1min = ($urandom_range(0, 2) == 0);
         bus.snooze = ($urandom_range(0, 11) == 0);
         bus.dismiss = ($urandom_range(0, 19) == 0);
         step("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
